// File: rtl/gpu_video_pkg.sv
// Shared constants and types for the GPU video path: default 640x480@60 raster timing,
// coordinate/index widths and the sync/enable tag carried down the alignment delay line.
package gpu_video_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned INDEX_W = 9;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic enable;
  } scan_tag_t;

  // Value of a tag outside the active region with both syncs deasserted.
  localparam scan_tag_t TAG_IDLE = '{hsync: 1'b1, vsync: 1'b1, enable: 1'b0};

endpackage

// File: rtl/scan_counter.sv
// Raster x/y wrap counters with registered active-region enable and raw sync decode.
// Nothing is issued until the first pix_ce after reset, which issues (0,0).
module scan_counter
  import gpu_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output scan_tag_t          tag,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic               running_q, running_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  scan_tag_t          tag_q, tag_d;
  logic               fs_q, fs_d;

  always_comb begin
    running_d = running_q;
    x_d       = x_q;
    y_d       = y_q;
    tag_d     = tag_q;
    fs_d      = 1'b0;
    if (pix_ce) begin
      running_d = 1'b1;
      if (!running_q) begin
        x_d  = '0;
        y_d  = '0;
        fs_d = 1'b1;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
      // Decode from the coordinate being issued so the tag changes together with x/y.
      tag_d.enable = (x_d < X_ACT) && (y_d < Y_ACT);
      tag_d.hsync  = !((x_d >= HS_START) && (x_d < HS_END));
      tag_d.vsync  = !((y_d >= VS_START) && (y_d < VS_END));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      tag_q     <= TAG_IDLE;
      fs_q      <= 1'b0;
    end else begin
      running_q <= running_d;
      x_q       <= x_d;
      y_q       <= y_d;
      tag_q     <= tag_d;
      fs_q      <= fs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign tag         = tag_q;
  assign frame_start = fs_q;

endmodule

// File: rtl/vga_scan_driver.sv
// Raster scan-out: issues coordinates to the layer pipeline, delays sync/enable by PIPE_LAT
// pixel ticks and registers the returned palette index alongside aligned sync and blank.
module vga_scan_driver
  import gpu_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               enable,
  input  logic [INDEX_W-1:0] index_in,
  output logic [INDEX_W-1:0] index_out,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               frame_start
);

  scan_tag_t          tag;
  scan_tag_t          dly_q [PIPE_LAT];
  scan_tag_t          dly_out;
  logic [INDEX_W-1:0] index_q;
  logic               hsync_q;
  logic               vsync_q;
  logic               blank_q;

  scan_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_scan_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .x           (x),
    .y           (y),
    .tag         (tag),
    .frame_start (frame_start)
  );

  // One stage per layer-pipeline register, so dly_out lines up with index_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) dly_q[i] <= TAG_IDLE;
    end else if (pix_ce) begin
      dly_q[0] <= tag;
      for (int i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign dly_out = dly_q[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b1;
    end else if (pix_ce) begin
      index_q <= dly_out.enable ? index_in : '0;
      hsync_q <= dly_out.hsync;
      vsync_q <= dly_out.vsync;
      blank_q <= !dly_out.enable;
    end
  end

  assign enable    = tag.enable;
  assign index_out = index_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver on a reduced 16x8 raster (8x4 visible) with a two-register
// layer pipeline returning {1, y[2:0], x[4:0]} for every issued coordinate.
module tb_vga_scan_driver;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int PL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic [9:0] x, y;
  logic       enable;
  logic [8:0] index_in, index_out;
  logic       hsync, vsync, blank, frame_start;
  logic [8:0] p1 = '0, p2 = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fs = -1;
  int hs_run = 0;
  int vs_total = 0;

  typedef struct {
    int         n;
    logic [9:0] x, y;
    logic       en, hs, vs, bl, fs;
    logic [8:0] idx;
  } vec_t;

  vec_t tbl[14];

  vga_scan_driver #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .PIPE_LAT (PL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .x           (x),
    .y           (y),
    .enable      (enable),
    .index_in    (index_in),
    .index_out   (index_out),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Layer pipeline model: fixed latency of PL pix_ce ticks.
  always @(posedge clk) begin
    if (pix_ce) begin
      p1 <= {1'b1, y[2:0], x[4:0]};
      p2 <= p1;
    end
  end
  assign index_in = p2;

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s tick %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic step(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    pix_ce = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    last_fs = -1;
    hs_run  = 0;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_x"}, 0, x, 0);
    chk({nm, "_y"}, 0, y, 0);
    chk({nm, "_enable"}, 0, enable, 0);
    chk({nm, "_index_out"}, 0, index_out, 0);
    chk({nm, "_hsync"}, 0, hsync, 1);
    chk({nm, "_vsync"}, 0, vsync, 1);
    chk({nm, "_blank"}, 0, blank, 1);
    chk({nm, "_frame_start"}, 0, frame_start, 0);
  endtask

  // Expected state after the n-th pix_ce since reset; hold marks the idle clk that follows.
  task automatic check_tick(input int n, input bit hold);
    int k, cx, cy, kk, ox, oy;
    logic act, ehs, evs;
    logic [8:0] eidx;
    k  = n - 1;
    cx = k % HT;
    cy = (k / HT) % VT;
    chk("x", n, x, cx);
    chk("y", n, y, cy);
    chk("enable", n, enable, (cx < HA) && (cy < VA));
    chk("frame_start", n, frame_start, !hold && (k % FT == 0));
    act = 1'b0; ehs = 1'b1; evs = 1'b1; eidx = '0;
    if (n >= PL + 2) begin
      kk  = n - 2 - PL;
      ox  = kk % HT;
      oy  = (kk / HT) % VT;
      act = (ox < HA) && (oy < VA);
      ehs = !((ox >= HA + HF) && (ox < HA + HF + HS));
      evs = !((oy >= VA + VF) && (oy < VA + VF + VS));
      eidx = act ? 9'(256 + (oy % 8) * 32 + (ox % 32)) : 9'd0;
    end
    chk("index_out", n, index_out, eidx);
    chk("blank", n, blank, !act);
    chk("hsync", n, hsync, ehs);
    chk("vsync", n, vsync, evs);
  endtask

  task automatic check_table(input int n);
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].n == n) begin
        chk("tbl_x", n, x, tbl[i].x);
        chk("tbl_y", n, y, tbl[i].y);
        chk("tbl_enable", n, enable, tbl[i].en);
        chk("tbl_hsync", n, hsync, tbl[i].hs);
        chk("tbl_vsync", n, vsync, tbl[i].vs);
        chk("tbl_blank", n, blank, tbl[i].bl);
        chk("tbl_frame_start", n, frame_start, tbl[i].fs);
        chk("tbl_index_out", n, index_out, tbl[i].idx);
      end
    end
  endtask

  task automatic track(input int n, input int clks_per_tick);
    if (frame_start) begin
      if (last_fs >= 0) chk("frame_period", n, cyc - last_fs, FT * clks_per_tick);
      last_fs = cyc;
    end
    if (!hsync) begin
      hs_run++;
    end else if (hs_run != 0) begin
      chk("hsync_width", n, hs_run, HS);
      hs_run = 0;
    end
    if (!vsync) vs_total++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            n    x      y     en    hs    vs    bl    fs    idx
    tbl[0]  = '{  1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'h000};
    tbl[1]  = '{  4, 10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h100};
    tbl[2]  = '{ 11, 10'd10, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h107};
    tbl[3]  = '{ 12, 10'd11, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000};
    tbl[4]  = '{ 14, 10'd13, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000};
    tbl[5]  = '{ 16, 10'd15, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000};
    tbl[6]  = '{ 17, 10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000};
    tbl[7]  = '{ 54, 10'd5, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h162};
    tbl[8]  = '{ 83, 10'd2, 10'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000};
    tbl[9]  = '{ 84, 10'd3, 10'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000};
    tbl[10] = '{128, 10'd15, 10'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000};
    tbl[11] = '{129, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'h000};
    tbl[12] = '{131, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000};
    tbl[13] = '{132, 10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h100};

    pix_ce = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check_idle("reset");
    do_reset();

    // Nothing is issued while pix_ce stays low after release.
    step(1'b0);
    step(1'b0);
    check_idle("ce_low");

    // Continuous pix_ce: two full frames plus a few ticks.
    vs_total = 0;
    for (int n = 1; n <= 2 * FT + 4; n++) begin
      step(1'b1);
      check_tick(n, 1'b0);
      check_table(n);
      track(n, 1);
    end
    chk("vsync_low_ticks", 0, vs_total, 2 * VS * HT);

    // pix_ce every other clk: same sequence, stretched, frame_start one clk wide.
    do_reset();
    for (int n = 1; n <= FT + 12; n++) begin
      step(1'b1);
      check_tick(n, 1'b0);
      check_table(n);
      track(n, 2);
      step(1'b0);
      check_tick(n, 1'b1);
    end

    // Asynchronous reset mid-frame at x=5, y=2 while outputs are active.
    do_reset();
    for (int n = 1; n <= 2 * HT + 6; n++) step(1'b1);
    chk("pre_reset_x", 0, x, 5);
    chk("pre_reset_y", 0, y, 2);
    chk("pre_reset_blank", 0, blank, 0);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step(1'b1);
      check_tick(n, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Raster timing and scan-out block for the GPU video path. It generates the pixel coordinates and the active-region enable that drive the background/layer pixel pipeline. It then captures the 9-bit palette index that pipeline returns and emits it to the palette/DAC stage, aligned with horizontal sync, vertical sync and blanking. It is the requesting end of the coordinate → index interface that the layer fillers answer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_LAT, 2, pix_ce ticks from x/y/enable out to a valid index_in (1..8)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel-rate clock enable; all state advances only when high
- x  out  10  current horizontal coordinate to the layer pipeline
- y  out  10  current vertical coordinate to the layer pipeline
- enable  out  1  high when (x,y) is inside the active region
- index_in  in  9  palette index returned by the layer pipeline
- index_out  out  9  aligned palette index to the palette/DAC stage
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  high outside the active region, aligned with index_out
- frame_start  out  1  one-clk pulse when x=0,y=0 is issued

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Counters: on each pix_ce, x increments.
  - When x=H_TOTAL-1, x wraps to 0 and y increments.
  - When y=V_TOTAL-1 and x=H_TOTAL-1, both x and y wrap to 0.
- enable = (x < H_ACTIVE) && (y < V_ACTIVE). It is a registered output that changes together with x and y.
- Raw sync is derived from the issued x and y:
  - hsync_raw low for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_raw low for V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491).
- Delay line: hsync_raw, vsync_raw and enable are shifted through PIPE_LAT pix_ce-qualified stages, so they line up with index_in.
- Output stage, on pix_ce:
  - index_out ← delayed_enable ? index_in : 0
  - hsync, vsync ← delayed raw values
  - blank ← ~delayed_enable
- frame_start is asserted for exactly one clk, on the clk where x/y transition to 0,0 (qualified by pix_ce).
- With pix_ce low, every register holds and frame_start is 0.
- Reset (asynchronous, mid-frame included):
  - x=0, y=0, enable=0, delay line cleared to inactive.
  - index_out=0, hsync=1, vsync=1, blank=1, frame_start=0.
  - After release, the first pix_ce issues x=0, y=0, enable=1 and asserts frame_start.

## Timing
- x, y and enable update one clk after a sampled pix_ce.
- index_in is sampled on the PIPE_LAT-th pix_ce after the corresponding coordinate was issued.
- index_out, hsync, vsync and blank appear PIPE_LAT+1 pix_ce ticks after their coordinate.
- All outputs are registered; there are no combinational paths from index_in to any output.
- No backpressure exists. The layer pipeline is required to return one index per pix_ce at fixed latency.

## Structure
- Shared package gpu_video_pkg:
  - default timing constants (H_*/V_*)
  - COORD_W=10, INDEX_W=9
  - a typedef for the {hsync, vsync, enable} delay-line entry
- Sub-module scan_counter holds the x/y wrap counters and the enable/raw-sync decode. The top level holds the alignment delay line and the output registers.

## Test plan
- Reset then 1 frame with pix_ce=1 every clk → exactly 800×525 ticks between frame_start pulses; x runs 0..799, and y advances once per line.
- index_in = x[8:0] echoed through a PIPE_LAT=2 model → index_out at each active pixel equals the x issued 3 ticks earlier; index_out=0 whenever blank=1.
- Line 0 → hsync low for exactly 96 ticks, starting at output tick of x=656. Frame → vsync low during lines 490–491 only.
- pix_ce toggled 1-of-2 clks → all outputs identical to the continuous run, but stretched ×2; frame_start stays 1 clk wide.
- Assert rst_n low at x=300,y=200 → outputs immediately reach index_out=0, hsync=1, vsync=1, blank=1. After release, the first issued coordinate is 0,0 and frame_start pulses.
- Frame wrap boundary: x=799,y=524 → next issued coordinate is 0,0 with enable=1 and frame_start=1. The blank output remains 1 until PIPE_LAT+1 ticks later.
